thermal_tx_scheduler: RTL and testbench

- Sequences the on-die heater banks (the inverter-chain heater plus its LED indicator) to send bytes over the temporal thermal channel using on-off keying.
- Accepts bytes over a valid/ready handshake and frames each byte as preamble, data bits MSB first, then a cool-down guard interval.
- Drives one enable per heater bank; each heater instance gates its toggling on its enable bit.

---
 rtl/thermal_tx_scheduler_if.sv | 23 ++
 rtl/thermal_tx_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_thermal_tx_scheduler.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/thermal_tx_scheduler_if.sv
// Byte handshake between a data source and thermal_tx_scheduler.
// master drives data_in/data_valid, slave returns data_ready.
interface thermal_tx_scheduler_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/thermal_tx_scheduler.sv
// Thermal channel transmitter: frames each accepted byte as an alternating
// preamble, MSB-first data bits and a heater-off guard interval, driving all
// heater banks with the same on-off keyed enable.
// Optional build macro THERMAL_TX_MANCHESTER_EN: each data bit is sent as two
// half-bits (1 = on/off, 0 = off/on); preamble, guard and frame length unchanged.
module thermal_tx_scheduler #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned N_BANKS    = 4,
  parameter int unsigned PERIOD_W   = 32,
  parameter int unsigned PRE_BITS   = 4,
  parameter int unsigned GUARD_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PERIOD_W-1:0]  cfg_bit_period,
  input  logic                 abort,
  thermal_tx_scheduler_if.slave tx,
  output logic [N_BANKS-1:0]   heater_en,
  output logic                 busy,
  output logic                 bit_tick,
  output logic                 frame_done
);

  localparam int unsigned MaxPreData = (PRE_BITS > DATA_W) ? PRE_BITS : DATA_W;
  localparam int unsigned MaxBits    = (MaxPreData > GUARD_BITS) ? MaxPreData : GUARD_BITS;
  localparam int unsigned BitW       = (MaxBits > 1) ? $clog2(MaxBits) : 1;

  typedef enum logic [1:0] {StIdle, StPre, StData, StGuard} state_e;

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [BitW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic                aborted_q, aborted_d;

  logic [N_BANKS-1:0]  heater_q, heater_d;
  logic                busy_q, busy_d;
  logic                tick_q, tick_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;
  logic                heater_bit;

  logic [PERIOD_W-1:0] eff_period;
  logic                accept;
  logic                period_end;
  logic                abort_hit;
  logic                last_pre, last_data, last_guard;

  // Periods below 2 cycles are clamped so every bit has a distinct tick cycle.
  assign eff_period = (cfg_bit_period < PERIOD_W'(2)) ? PERIOD_W'(2) : cfg_bit_period;
  assign accept     = (state_q == StIdle) && tx.data_valid && ready_q;
  assign period_end = (cnt_q == '0);
  assign abort_hit  = abort && ((state_q == StPre) || (state_q == StData));
  assign last_pre   = (bit_q == BitW'(PRE_BITS - 1));
  assign last_data  = (bit_q == BitW'(DATA_W - 1));
  assign last_guard = (bit_q == BitW'(GUARD_BITS - 1));

  assign heater_en     = heater_q;
  assign busy          = busy_q;
  assign bit_tick      = tick_q;
  assign frame_done    = done_q;
  assign tx.data_ready = ready_q;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus bit counter, period and shift register updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    aborted_d = aborted_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d   = StPre;
          period_d  = eff_period;
          cnt_d     = eff_period - PERIOD_W'(1);
          bit_d     = '0;
          sh_d      = tx.data_in;
          aborted_d = 1'b0;
        end
      end
      StPre, StData: begin
        if (abort_hit) begin
          // Abandon the frame but still enforce a full cool-down.
          state_d   = StGuard;
          cnt_d     = period_q - PERIOD_W'(1);
          bit_d     = '0;
          aborted_d = 1'b1;
        end else if (period_end) begin
          cnt_d = period_q - PERIOD_W'(1);
          if ((state_q == StPre) ? last_pre : last_data) begin
            state_d = (state_q == StPre) ? StData : StGuard;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BitW'(1);
            if (state_q == StData) begin
              sh_d = sh_q << 1;
            end
          end
        end else begin
          cnt_d = cnt_q - PERIOD_W'(1);
        end
      end
      StGuard: begin
        if (period_end) begin
          if (last_guard) begin
            state_d = StIdle;
          end else begin
            bit_d = bit_q + BitW'(1);
            cnt_d = period_q - PERIOD_W'(1);
          end
        end else begin
          cnt_d = cnt_q - PERIOD_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef THERMAL_TX_MANCHESTER_EN
  logic [PERIOD_W-1:0] half_d;
  // Counter values >= ceil(P/2) form the first floor(P/2) cycles of a bit.
  assign half_d = period_d - (period_d >> 1);
`endif

  // Output values for the next cycle, derived from the next state.
  always_comb begin
    heater_bit = 1'b0;
    unique case (state_d)
      StPre:  heater_bit = ~bit_d[0];
`ifdef THERMAL_TX_MANCHESTER_EN
      StData: heater_bit = sh_d[DATA_W-1] ^ (cnt_d < half_d);
`else
      StData: heater_bit = sh_d[DATA_W-1];
`endif
      default: heater_bit = 1'b0;
    endcase
    heater_d = {N_BANKS{heater_bit}};
    busy_d   = (state_d != StIdle);
    ready_d  = (state_d == StIdle);
    tick_d   = accept ||
               ((state_q != StIdle) && (state_d != StIdle) && (period_end || abort_hit));
    done_d   = (state_q == StGuard) && (state_d == StIdle) && !aborted_q;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      period_q  <= PERIOD_W'(2);
      bit_q     <= '0;
      sh_q      <= '0;
      aborted_q <= 1'b0;
      heater_q  <= '0;
      busy_q    <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      aborted_q <= aborted_d;
      heater_q  <= heater_d;
      busy_q    <= busy_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

endmodule

// File: tb/tb_thermal_tx_scheduler.sv
// Self-checking bench for thermal_tx_scheduler: directed and random frames
// compared cycle by cycle against a frame model indexed by cycle number.
module tb_thermal_tx_scheduler;

  localparam int DW  = 8;
  localparam int NB  = 4;
  localparam int PW  = 32;
  localparam int PRE = 4;
  localparam int GRD = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] cfg;
  logic          abort;
  logic [NB-1:0] heater_en;
  logic          busy;
  logic          bit_tick;
  logic          frame_done;

  int n_assert = 0;
  int n_fail   = 0;

  thermal_tx_scheduler_if #(.DATA_W(DW)) tx_bus ();

  thermal_tx_scheduler #(
    .DATA_W    (DW),
    .N_BANKS   (NB),
    .PERIOD_W  (PW),
    .PRE_BITS  (PRE),
    .GUARD_BITS(GRD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_bit_period(cfg),
    .abort         (abort),
    .tx            (tx_bus),
    .heater_en     (heater_en),
    .busy          (busy),
    .bit_tick      (bit_tick),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic heat;
    logic busy;
    logic tick;
    logic done;
    logic ready;
    logic quiet;  // abort must be ignored in this cycle (guard or idle)
  } exp_t;

  exp_t q[$];

  function automatic exp_t mk(logic h, logic b, logic t, logic d, logic r, logic qt);
    exp_t e;
    e.heat = h; e.busy = b; e.tick = t; e.done = d; e.ready = r; e.quiet = qt;
    return e;
  endfunction

  // Expected heater level in busy cycle k of an unaborted frame.
  function automatic logic heat_at(logic [DW-1:0] b, int p, int k);
    int   n;
    logic d;
    n = k / p;
    if (n < PRE) return (n % 2) == 0;
    if (n < PRE + DW) begin
      d = b[DW-1-(n-PRE)];
`ifdef THERMAL_TX_MANCHESTER_EN
      return ((k % p) < (p / 2)) ? d : ~d;
`else
      return d;
`endif
    end
    return 1'b0;
  endfunction

  function automatic int eff(int c);
    return (c < 2) ? 2 : c;
  endfunction

  task automatic model_frame(input logic [DW-1:0] b, input int c, input int abort_at);
    int p;
    int len;
    p   = eff(c);
    len = (abort_at < 0) ? (PRE + DW + GRD) * p : abort_at + 1;
    for (int k = 0; k < len; k++) begin
      q.push_back(mk(heat_at(b, p, k), 1'b1, (k % p) == 0, 1'b0, 1'b0, k >= (PRE + DW) * p));
    end
    if (abort_at >= 0) begin
      for (int j = 0; j < GRD * p; j++) begin
        q.push_back(mk(1'b0, 1'b1, (j % p) == 0, 1'b0, 1'b0, 1'b1));
      end
    end
    q.push_back(mk(1'b0, 1'b0, 1'b0, abort_at < 0, 1'b1, 1'b1));
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Step through queued expectations, one per cycle, sampling on the falling edge.
  task automatic run_queue(input int abort_at, input bit keep_valid,
                           input logic [DW-1:0] next_byte, input bit scramble,
                           input int max_n);
    int   idx;
    exp_t e;
    idx = 0;
    while (q.size() > 0 && idx < max_n) begin
      @(negedge clk);
      e = q.pop_front();
      chk($sformatf("heater_en[%0d]", idx), heater_en, {NB{e.heat}});
      chk($sformatf("busy[%0d]", idx), busy, e.busy);
      chk($sformatf("bit_tick[%0d]", idx), bit_tick, e.tick);
      chk($sformatf("frame_done[%0d]", idx), frame_done, e.done);
      chk($sformatf("data_ready[%0d]", idx), tx_bus.data_ready, e.ready);
      if (idx == 0) begin
        if (keep_valid) tx_bus.data_in = next_byte;
        else tx_bus.data_valid = 1'b0;
      end
      if (scramble) cfg = $urandom;
      abort = (idx == abort_at) || (e.quiet && ($urandom_range(0, 3) == 0));
      idx++;
    end
  endtask

  task automatic send(input logic [DW-1:0] b, input int c, input int abort_at,
                      input bit scramble);
    tx_bus.data_in    = b;
    tx_bus.data_valid = 1'b1;
    cfg               = PW'(c);
    model_frame(b, c, abort_at);
    run_queue(abort_at, 1'b0, '0, scramble, 1 << 30);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    run_queue(-1, 1'b0, '0, 1'b0, n);
  endtask

  initial begin
    logic [DW-1:0] rb;
    int            rc;
    int            ra;

    reset             = 1'b1;
    cfg               = PW'(4);
    abort             = 1'b0;
    tx_bus.data_in    = '0;
    tx_bus.data_valid = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_heater_en", heater_en, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bit_tick", bit_tick, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_data_ready", tx_bus.data_ready, 1'b0);
    reset = 1'b0;
    idle(2);

    // Basic frame, then clamped periods.
    send(8'hA5, 4, -1, 1'b0);
    send(8'hFF, 0, -1, 1'b0);
    send(8'hFF, 1, -1, 1'b0);

    // Back-to-back with data_valid held: second byte taken in the frame_done cycle.
    tx_bus.data_in    = 8'h01;
    tx_bus.data_valid = 1'b1;
    cfg               = PW'(3);
    model_frame(8'h01, 3, -1);
    run_queue(-1, 1'b1, 8'h80, 1'b0, 1 << 30);
    model_frame(8'h80, 3, -1);
    run_queue(-1, 1'b0, '0, 1'b0, 1 << 30);

    // Abort in DATA bit 3 with P=8.
    send(8'h5A, 8, (PRE + 3) * 8 + 2, 1'b0);
    idle(1);

    // Half-bit case (plain keying when the optional macro is off).
    send(8'h80, 6, -1, 1'b0);

    // Random frames with mid-frame cfg changes and occasional aborts.
    for (int i = 0; i < 8; i++) begin
      rb = DW'($urandom);
      rc = int'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (PRE + DW) * eff(rc) - 1)) : -1;
      send(rb, rc, ra, 1'b1);
    end

    // Asynchronous reset in the middle of DATA.
    tx_bus.data_in    = 8'hFF;
    tx_bus.data_valid = 1'b1;
    cfg               = PW'(5);
    model_frame(8'hFF, 5, -1);
    run_queue(-1, 1'b0, '0, 1'b0, 27);
    q.delete();
    abort = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_heater_en", heater_en, '0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_data_ready", tx_bus.data_ready, 1'b0);
    chk("arst_bit_tick", bit_tick, 1'b0);
    chk("arst_frame_done", frame_done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    idle(3);
    send(8'hC3, 3, -1, 1'b1);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
